// File: rtl/crack_sched_if.sv
`default_nettype none
// ============================================================================
// crack_sched_if
// Start/result handshake plus per-core dispatch/completion bus for crack_sched.
// Revision: 1.0
// ============================================================================
interface crack_sched_if #(
    parameter int NCORES = 2
);
    logic                   en;
    logic                   rdy;
    logic                   key_valid;
    logic [23:0]            key;
    logic [NCORES-1:0]      core_en;
    logic [NCORES*24-1:0]   core_key;
    logic [NCORES-1:0]      core_rdy;
    logic [NCORES-1:0]      core_done;
    logic [NCORES-1:0]      core_found;

    // Scheduler side
    modport slave (
        input  en, core_rdy, core_done, core_found,
        output rdy, key_valid, key, core_en, core_key
    );

    // Start/result logic and core array side
    modport master (
        output en, core_rdy, core_done, core_found,
        input  rdy, key_valid, key, core_en, core_key
    );
endinterface
`default_nettype wire

// File: rtl/crack_sched.sv
`default_nettype none
// ============================================================================
// crack_sched
// Hands ascending 24-bit keys round-robin to idle ARC4 crack cores, stops on
// the first hit or key-space exhaustion, drains in-flight cores, reports result.
// Revision: 1.0
// ============================================================================
module crack_sched #(
    parameter int          NCORES   = 2,
    parameter logic [23:0] KEY_LAST = 24'hFFFFFF
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    crack_sched_if.slave bus
);
    localparam int         c_RRW     = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_RUN   = 3'd1;
    localparam logic [2:0] c_S_DRAIN = 3'd2;
    localparam logic [2:0] c_S_FLUSH = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [NCORES-1:0] r_busy;
    logic [NCORES-1:0] w_busy_nxt;
    logic [NCORES-1:0] r_core_en;
    logic [23:0]       r_key_arr [NCORES];
    logic [23:0]       r_next_key;
    logic [23:0]       r_found_key;
    logic [23:0]       r_key;
    logic              r_key_valid;
    logic [c_RRW-1:0]  r_rr;

    logic [NCORES-1:0] w_avail;
    logic [NCORES-1:0] w_hit_vec;
    logic [NCORES-1:0] w_disp_vec;
    logic              w_disp;
    logic [c_RRW-1:0]  w_disp_idx;
    logic [c_RRW-1:0]  v_idx;
    logic              w_hit_any;
    logic              w_hit;
    logic [c_RRW-1:0]  w_hit_idx;
    logic [23:0]       w_hit_key;
    logic              w_rdy;
    logic              w_start;
    logic              w_finish;
    logic              w_res_valid;
    logic [23:0]       w_res_key;
    logic [NCORES*24-1:0] w_core_key_flat;

    assign w_avail    = ~r_busy & bus.core_rdy;
    assign w_hit_vec  = bus.core_done & r_busy & bus.core_found;
    assign w_busy_nxt = (r_busy & ~bus.core_done) | w_disp_vec;

    // Search starts just after the last core served, so the first free core wins
    always_comb begin : p_dispatch
        w_disp     = 1'b0;
        w_disp_idx = '0;
        v_idx      = '0;
        w_disp_vec = '0;
        if (r_state == c_S_RUN) begin
            for (int k = NCORES; k >= 1; k--) begin
                v_idx = c_RRW'((int'(r_rr) + k) % NCORES);
                if (w_avail[v_idx]) begin
                    w_disp     = 1'b1;
                    w_disp_idx = v_idx;
                end
            end
        end
        for (int i = 0; i < NCORES; i++) begin
            w_disp_vec[i] = w_disp && (w_disp_idx == c_RRW'(i));
        end
    end

    always_comb begin : p_hit
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = c_RRW'(i);
            end
        end
    end

    assign w_hit       = w_hit_any && ((r_state == c_S_RUN) || (r_state == c_S_DRAIN));
    assign w_hit_key   = r_key_arr[w_hit_idx];
    assign w_start     = w_rdy && bus.en;
    assign w_finish    = (r_state != c_S_DONE) && (w_state_nxt == c_S_DONE);
    // A hit may finish the run in the same cycle it is seen, bypassing FLUSH
    assign w_res_valid = (r_state == c_S_FLUSH) || w_hit;
    assign w_res_key   = (r_state == c_S_FLUSH) ? r_found_key : w_hit_key;

    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (bus.en) w_state_nxt = c_S_RUN;
            end
            c_S_RUN: begin
                if (w_hit)
                    w_state_nxt = (w_busy_nxt == '0) ? c_S_DONE : c_S_FLUSH;
                else if (w_disp && (r_next_key == KEY_LAST))
                    w_state_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (w_hit)
                    w_state_nxt = (w_busy_nxt == '0) ? c_S_DONE : c_S_FLUSH;
                else if (w_busy_nxt == '0)
                    w_state_nxt = c_S_DONE;
            end
            c_S_FLUSH: begin
                if (w_busy_nxt == '0) w_state_nxt = c_S_DONE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin : p_out
        w_rdy = (r_state == c_S_IDLE) || (r_state == c_S_DONE);
        for (int i = 0; i < NCORES; i++) begin
            w_core_key_flat[24*i +: 24] = r_key_arr[i];
        end
    end

    assign bus.rdy       = w_rdy;
    assign bus.key_valid = r_key_valid;
    assign bus.key       = r_key;
    assign bus.core_en   = r_core_en;
    assign bus.core_key  = w_core_key_flat;

    always_ff @(posedge clk or negedge rst_n) begin : p_data
        if (!rst_n) begin
            r_busy      <= '0;
            r_core_en   <= '0;
            r_next_key  <= '0;
            r_rr        <= c_RRW'(NCORES - 1);
            r_found_key <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_core_en <= w_disp_vec;
            if (w_start) begin
                r_busy      <= '0;
                r_next_key  <= '0;
                r_rr        <= c_RRW'(NCORES - 1);
                r_key       <= '0;
                r_key_valid <= 1'b0;
            end else begin
                r_busy <= w_busy_nxt;
                if (w_disp) begin
                    r_rr <= w_disp_idx;
                    if (r_next_key != KEY_LAST) r_next_key <= r_next_key + 24'd1;
                end
                if (w_hit) r_found_key <= w_hit_key;
                if (w_finish) begin
                    r_key_valid <= w_res_valid;
                    r_key       <= w_res_valid ? w_res_key : 24'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_keys
        if (!rst_n) begin
            for (int i = 0; i < NCORES; i++) r_key_arr[i] <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (w_disp_vec[i]) r_key_arr[i] <= r_next_key;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_crack_sched.sv
`default_nettype none
// ============================================================================
// tb_crack_sched
// Mock crack cores plus a transaction-level scheduler model checked every cycle.
// Revision: 1.0
// ============================================================================
module tb_crack_sched;
    localparam int N  = 2;
    localparam int KL = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crack_sched_if #(.NCORES(N)) bus ();
    crack_sched #(.NCORES(N), .KEY_LAST(24'(KL))) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // stimulus controls
    logic [N-1:0] hold  = '0;
    logic [N-1:0] stray = '0;
    bit   rand_hold = 0;
    bit   junk_en   = 0;
    bit   en_req    = 0;
    int   mcnt [N];
    int   mkey [N];
    int   lat_tab   [256];
    bit   found_tab [256];
    int   disp_cnt  [256];
    int   disp_core1;

    // reference model: run flag, next key, hit record, in-flight keys per core
    bit           m_run, m_hit, m_rdy, m_kv;
    int           m_key, m_hitkey, m_next, m_rr;
    bit           m_inf   [N];
    int           m_inkey [N];
    logic [N-1:0] m_en_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_hit = 0; m_rdy = 1; m_kv = 0; m_key = 0; m_hitkey = 0;
        m_next = 0; m_rr = N - 1; m_en_exp = '0;
        for (int i = 0; i < N; i++) begin m_inf[i] = 0; m_inkey[i] = 0; end
    endtask

    task automatic clear_tables(input int lat);
        for (int k = 0; k < 256; k++) begin
            lat_tab[k] = lat; found_tab[k] = 0; disp_cnt[k] = 0;
        end
        disp_core1 = 0;
    endtask

    // One cycle: compare outputs, run mock cores, drive inputs, advance model
    task automatic tick();
        logic [N-1:0] done_v, found_v, crdy_v;
        logic         en_v;
        int           d;
        bit           was_run, any_inf;
        chk("rdy",       64'(bus.rdy),       64'(m_rdy));
        chk("key_valid", 64'(bus.key_valid), 64'(m_kv));
        chk("key",       64'(bus.key),       64'(m_key));
        chk("core_en",   64'(bus.core_en),   64'(m_en_exp));
        for (int i = 0; i < N; i++) begin
            chk("core_key", 64'(bus.core_key[24*i +: 24]), 64'(m_inkey[i]));
            done_v[i] = 1'b0;
            if (bus.core_en[i]) begin
                mkey[i] = int'(bus.core_key[24*i +: 24]) & 255;
                mcnt[i] = lat_tab[mkey[i]];
                disp_cnt[mkey[i]]++;
                if (i == 1) disp_core1++;
            end else if (mcnt[i] > 0) begin
                mcnt[i]--;
                if (mcnt[i] == 0) done_v[i] = 1'b1;
            end
            found_v[i] = done_v[i] ? found_tab[mkey[i]] : 1'($urandom);
            crdy_v[i]  = (mcnt[i] == 0) && !hold[i] && !(rand_hold && ($urandom_range(0, 3) == 0));
        end
        done_v = done_v | stray;
        stray  = '0;
        en_v   = en_req || (junk_en && !bus.rdy && 1'($urandom));
        bus.en = en_v; bus.core_done = done_v; bus.core_found = found_v; bus.core_rdy = crdy_v;

        if (rst_n) begin
            was_run = m_run;
            d = -1;
            if (m_run && !m_hit && m_next <= KL) begin
                for (int k = 1; k <= N; k++) begin
                    if (d < 0 && !m_inf[(m_rr + k) % N] && crdy_v[(m_rr + k) % N]) d = (m_rr + k) % N;
                end
            end
            m_en_exp = '0;
            for (int i = 0; i < N; i++) begin
                if (done_v[i] && m_inf[i]) begin
                    if (found_v[i] && m_run && !m_hit) begin m_hit = 1; m_hitkey = m_inkey[i]; end
                    m_inf[i] = 0;
                end
            end
            if (d >= 0) begin
                m_inf[d] = 1; m_inkey[d] = m_next; m_next++; m_rr = d; m_en_exp[d] = 1'b1;
            end
            any_inf = 0;
            for (int i = 0; i < N; i++) any_inf |= m_inf[i];
            if (m_run && (m_hit || m_next > KL) && !any_inf) begin
                m_run = 0; m_rdy = 1; m_kv = m_hit; m_key = m_hit ? m_hitkey : 0;
            end
            if (!was_run && en_v) begin
                m_run = 1; m_rdy = 0; m_kv = 0; m_key = 0; m_hit = 0; m_next = 0; m_rr = N - 1;
                for (int i = 0; i < N; i++) m_inf[i] = 0;
            end
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        en_req = 1; tick(); en_req = 0;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (bus.rdy !== 1'b1 && n < 600) begin tick(); n++; end
        chk({tag, "_timeout"}, 64'(n < 600), 64'd1);
        tick();
    endtask

    task automatic check_all_once(input string tag);
        for (int k = 0; k <= KL; k++) chk(tag, 64'(disp_cnt[k]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.en = 0; bus.core_rdy = '0; bus.core_done = '0; bus.core_found = '0;
        for (int i = 0; i < N; i++) begin mcnt[i] = 0; mkey[i] = 0; end
        clear_tables(5);
        model_reset();

        // reset values
        @(posedge clk); #1;
        chk("rst_rdy",       64'(bus.rdy),       64'd1);
        chk("rst_key_valid", 64'(bus.key_valid), 64'd0);
        chk("rst_key",       64'(bus.key),       64'd0);
        chk("rst_core_en",   64'(bus.core_en),   64'd0);
        chk("rst_core_key",  64'(bus.core_key),  64'd0);
        rst_n = 1;
        repeat (2) tick();

        // ordered dispatch, nothing found
        start_run();
        wait_rdy("nofind");
        check_all_once("nofind_once");
        chk("nofind_kv",  64'(bus.key_valid), 64'd0);
        chk("nofind_key", 64'(bus.key),       64'd0);

        // hit on key 5: key 6 already dispatched in the hit cycle, key 7 never
        clear_tables(5); found_tab[5] = 1;
        start_run();
        wait_rdy("hit");
        chk("hit_kv",   64'(bus.key_valid), 64'd1);
        chk("hit_key",  64'(bus.key),       64'd5);
        chk("hit_k6",   64'(disp_cnt[6]),   64'd1);
        chk("hit_k7",   64'(disp_cnt[7]),   64'd0);

        // restart from DONE with simultaneous hits on keys 2 (core0) and 3 (core1)
        clear_tables(5); found_tab[2] = 1; found_tab[3] = 1; lat_tab[3] = 4;
        start_run();
        chk("restart_kv", 64'(bus.key_valid), 64'd0);
        wait_rdy("simhit");
        chk("simhit_kv",  64'(bus.key_valid), 64'd1);
        chk("simhit_key", 64'(bus.key),       64'd2);

        // back-pressure on core1
        clear_tables(5); hold = 2'b10;
        start_run();
        repeat (30) tick();
        chk("bp_core1_idle", 64'(disp_core1), 64'd0);
        hold = '0;
        wait_rdy("bp");
        check_all_once("bp_once");
        chk("bp_kv", 64'(bus.key_valid), 64'd0);

        // asynchronous reset mid-run, stray done, restart at key 0
        clear_tables(5);
        start_run();
        repeat (8) tick();
        #3 rst_n = 0;
        #1;
        chk("mid_rst_rdy",      64'(bus.rdy),       64'd1);
        chk("mid_rst_kv",       64'(bus.key_valid), 64'd0);
        chk("mid_rst_key",      64'(bus.key),       64'd0);
        chk("mid_rst_core_en",  64'(bus.core_en),   64'd0);
        chk("mid_rst_core_key", 64'(bus.core_key),  64'd0);
        model_reset();
        tick();
        rst_n = 1;
        stray = 2'b10;
        repeat (10) tick();
        clear_tables(5);
        start_run();
        wait_rdy("after_rst");
        check_all_once("after_rst_once");

        // randomized runs
        rand_hold = 1; junk_en = 1;
        for (int r = 0; r < 8; r++) begin
            clear_tables(5);
            for (int k = 0; k <= KL; k++) begin
                lat_tab[k]   = $urandom_range(1, 7);
                found_tab[k] = (r % 3 != 0) && ($urandom_range(0, 5) == 0);
            end
            repeat ($urandom_range(0, 3)) tick();
            start_run();
            wait_rdy("rand");
        end
        rand_hold = 0; junk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/crack_sched.md
# crack_sched

Key-space scheduler for the parallel ARC4 cracking circuit. It sits between the top-level start/result logic and `NCORES` identical crack cores. Each core is an ARC4 decrypt plus plaintext checker that tests one key and reports found / not-found. The scheduler hands out 24-bit candidate keys in ascending order, one dispatch per cycle, round-robin over idle cores. It stops on the first hit or when the key space is exhausted, waits for in-flight cores to drain, and reports the result through the codebase's `en`/`rdy` handshake.

## Interface
Parameters:
- `NCORES`, default 2: number of crack cores (1..8).
- `KEY_LAST`, default 24'hFFFFFF: last key dispatched. Benches use small values.

Ports:
- `clk`  in  1  system clock; the single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  high when idle and able to accept `en`.
- `key_valid`  out  1  result flag; 1 means `key` holds the found key.
- `key`  out  24  found key; 0 when not found.
- `core_en`  out  NCORES  one-cycle start pulse per core.
- `core_key`  out  NCORES*24  per-core key, slice i = bits [24i+23:24i]; held while that core is busy.
- `core_rdy`  in  NCORES  core i can accept `core_en[i]`.
- `core_done`  in  NCORES  one-cycle pulse, core i finished its key.
- `core_found`  in  NCORES  valid with `core_done[i]`; 1 means the key decrypted to valid plaintext.

## Operation
- **Per-core state:** `busy[i]`, assigned key register.
- **Scheduler state:** `next_key` (24 bit), round-robin pointer `rr` (index of the last core dispatched), found-key register, FSM.
- **IDLE**
  - `rdy`=1.
  - `en`=1 → clear `busy`, `next_key`=0, `rr`=NCORES-1, clear result, go to RUN.
- **RUN**
  - Each cycle, search cores `rr`+1 … `rr`+NCORES (mod NCORES) for the first with `busy`=0 and `core_rdy`=1.
  - If one is found: pulse `core_en[i]` next cycle, load `core_key[i]`=`next_key`, set `busy[i]`, set `rr`=i, increment `next_key`.
  - At most one dispatch per cycle.
  - Dispatching `KEY_LAST` → DRAIN. `next_key` never wraps; no key beyond `KEY_LAST` is dispatched.
- **Completion handling (all states)**
  - `core_done[i]` with `busy[i]`=1 clears `busy[i]`.
  - `core_done[i]` with `busy[i]`=0 is ignored.
- **Found handling**
  - In RUN or DRAIN, any accepted `core_done[i]` & `core_found[i]` captures that core's assigned key and goes to FLUSH.
  - Several hits in the same cycle: the lowest index wins.
  - A completion arriving in the same cycle as a dispatch to a different core is handled in that cycle; the dispatch still occurs if the FSM is in RUN.
- **DRAIN:** no dispatch; hit → FLUSH; all `busy` clear → DONE with `key_valid`=0, `key`=0.
- **FLUSH:** no dispatch; later hits are ignored; all `busy` clear → DONE with `key_valid`=1, `key`=captured key.
- **DONE**
  - `rdy`=1; `key_valid` and `key` are held.
  - `en` → behaves as in IDLE: clears the result and restarts.
- Exactly one dispatch per key in [0, `KEY_LAST`] unless a hit stops dispatch early.

## Timing
- **Reset values:** `rdy`=1, `key_valid`=0, `key`=0, `core_en`=0, `core_key`=0, FSM=IDLE, `busy`=0.
- **Reset mid-run:** all of the above are restored immediately (asynchronous reset); in-flight core results are discarded.
- **Start latency:**
  - `en` accepted at edge N → `rdy`=0 after N.
  - First `core_en` pulse is high in cycle N+1 (registered decision made in the first RUN cycle, N+1 edge).
  - With all cores ready, consecutive cores receive pulses on consecutive cycles.
- **Core handshake:** `core_en[i]` is high exactly one cycle; `core_key[i]` is valid in that cycle and stays stable until the next dispatch to core i.
- **Result latency:** `rdy`=1 and the result are visible the cycle after the edge on which the last `busy` bit clears.
- **Ignored input:** `en` while `rdy`=0 is ignored.

## Test plan
- **Ordered dispatch, not found:** `NCORES`=2, `KEY_LAST`=7, mock cores with `core_done` 5 cycles after `core_en`, never found → keys 0..7 dispatched alternately core0/core1, each exactly once; finally `rdy`=1, `key_valid`=0, `key`=0.
- **Hit:** same setup, core finishing key 5 asserts found → no key above the in-flight set dispatched after the hit; `key_valid`=1, `key`=5 only after the other core's done.
- **Simultaneous hits:** both cores found in the same cycle (keys 2 on core0, 3 on core1) → `key`=2.
- **Back-pressure:** hold `core_rdy[1]`=0 → all keys go to core0 in order; release → round-robin resumes at core1.
- **Reset and stray done:** assert `rst_n`=0 mid-RUN → all outputs at reset values; after release, a `core_done` pulse on an idle core is ignored, `en` restarts at key 0.
- **Restart from DONE:** `en` in DONE with `key_valid`=1 → `key_valid` clears and dispatch restarts at key 0.
